msg_streamer: RTL and testbench

- Streams a terminator-delimited byte string from a synchronous read-only memory to a byte sink (UART transmitter) over a valid/ready handshake.
- Generalised successor to the fixed hello-string stepping logic: parametrised address and data width, selectable start address per transfer, configurable terminator, length limit, byte counter and completion pulse.
- Sits between a BRAM text store and the UART inside the SoC top level.

---
 rtl/msg_pkg.sv | 20 ++
 rtl/msg_streamer.sv | 128 ++++++++++++
 tb/tb_msg_streamer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/msg_pkg.sv
// Shared encodings for the message streamer: FSM states, line-ending characters
// and the length counter width.
package msg_pkg;

    localparam int LEN_W = 16;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CHECK = 3'd2,
        SEND  = 3'd3,
        FIN   = 3'd4,
        CR    = 3'd5,
        LF    = 3'd6
    } state_e;

endpackage

// File: rtl/msg_streamer.sv
// Streams a terminator-delimited string from a synchronous ROM to a valid/ready byte sink.
// Optional: define MSG_STREAMER_CRLF_EN to append CR LF after each message.
module msg_streamer
    import msg_pkg::*;
#(
    parameter int unsigned            AddrWidth  = 19,
    parameter int unsigned            DataWidth  = 8,
    parameter logic [DataWidth-1:0]   Terminator = '0,
    parameter int unsigned            MaxLen     = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [AddrWidth-1:0] BASE,
    output logic [AddrWidth-1:0] ROM_ADDR,
    input  logic [DataWidth-1:0] ROM_DATA,
    output logic [DataWidth-1:0] TX_DATA,
    output logic                 TX_VALID,
    input  logic                 TX_READY,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 OVF,
    output logic [LEN_W-1:0]     LEN
);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 ovf_q, ovf_d;
    logic [LEN_W-1:0]     len_q, len_d;

    logic hs;
    logic is_term;
    logic at_max;

    assign hs      = tx_valid_q & TX_READY;
    assign is_term = (ROM_DATA == Terminator);
    assign at_max  = (len_q == LEN_W'(MaxLen));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
            len_q      <= len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ovf_d      = ovf_q;
        len_d      = len_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    addr_d  = BASE;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = CHECK;
            CHECK: begin
                if (is_term || at_max) begin
                    // Terminator takes priority, so a message of exactly MaxLen bytes is not an overflow.
                    ovf_d = ovf_q | (~is_term & at_max);
`ifdef MSG_STREAMER_CRLF_EN
                    tx_data_d  = DataWidth'(CHAR_CR);
                    tx_valid_d = 1'b1;
                    state_d    = CR;
`else
                    state_d    = FIN;
`endif
                end else begin
                    tx_data_d  = ROM_DATA;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    len_d      = len_q + 1'b1;
                    addr_d     = addr_q + 1'b1;
                    state_d    = FETCH;
                end
            end
`ifdef MSG_STREAMER_CRLF_EN
            CR: begin
                if (hs) begin
                    tx_data_d = DataWidth'(CHAR_LF);
                    state_d   = LF;
                end
            end
            LF: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = FIN;
                end
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ROM_ADDR = addr_q;
    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign BUSY     = (state_q != IDLE);
    assign DONE     = (state_q == FIN);
    assign OVF      = ovf_q;
    assign LEN      = len_q;

endmodule

// File: tb/tb_msg_streamer.sv
// Directed bench for msg_streamer: default instance plus a MaxLen=4 instance sharing one ROM image.
module tb_msg_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        ready = 1'b1;
    logic [18:0] base = '0;

    logic [18:0] rom_addr, rom_addr2;
    logic [7:0]  rom_data = '0, rom_data2 = '0;
    logic [7:0]  tx_data, tx_data2;
    logic        tx_valid, tx_valid2, busy, busy2, done, done2, ovf, ovf2;
    logic [15:0] len, len2;

    logic [7:0]  mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= mem[rom_addr[7:0]];
        rom_data2 <= mem[rom_addr2[7:0]];
    end

    msg_streamer u_dut (
        .CLK(clk), .RST(rst), .START(start), .BASE(base),
        .ROM_ADDR(rom_addr), .ROM_DATA(rom_data),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(ready),
        .BUSY(busy), .DONE(done), .OVF(ovf), .LEN(len)
    );

    msg_streamer #(.MaxLen(4)) u_dut2 (
        .CLK(clk), .RST(rst), .START(start2), .BASE(base),
        .ROM_ADDR(rom_addr2), .ROM_DATA(rom_data2),
        .TX_DATA(tx_data2), .TX_VALID(tx_valid2), .TX_READY(ready),
        .BUSY(busy2), .DONE(done2), .OVF(ovf2), .LEN(len2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered with u_dut in CHECK looking at the terminator; a START during DONE must be ignored.
    task automatic tail(input string tag, input logic [31:0] exp_len);
`ifdef MSG_STREAMER_CRLF_EN
        tick();
        chk({tag, "_cr_vld"}, 32'(tx_valid), 1);
        chk({tag, "_cr"}, 32'(tx_data), 'h0D);
        tick();
        chk({tag, "_lf_vld"}, 32'(tx_valid), 1);
        chk({tag, "_lf"}, 32'(tx_data), 'h0A);
`endif
        tick();
        chk({tag, "_done"}, 32'(done), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_done_drop"}, 32'(done), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
        chk({tag, "_len"}, 32'(len), exp_len);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h2E;
        mem['h10] = "H"; mem['h11] = "I"; mem['h12] = 8'h00;
        mem['h20] = 8'h00;
        for (int i = 0; i < 10; i++) mem['h30 + i] = 8'(8'h30 + i);
        mem['h3A] = 8'h00;
        mem['h40] = "O"; mem['h41] = "K"; mem['h42] = 8'h00;
        mem['h50] = "A"; mem['h51] = 8'h00;

        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_vld", 32'(tx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_len", 32'(len), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_data", 32'(tx_data), 0);

        // "HI" with sink always ready
        base = 19'h10; start = 1'b1; ready = 1'b1;
        tick(); start = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_addr", 32'(rom_addr), 'h10);
        chk("t1_vld0", 32'(tx_valid), 0);
        tick();
        chk("t1_vld1", 32'(tx_valid), 0);
        tick();
        chk("t1_h_vld", 32'(tx_valid), 1);
        chk("t1_h", 32'(tx_data), "H");
        tick();
        chk("t1_h_drop", 32'(tx_valid), 0);
        chk("t1_len1", 32'(len), 1);
        chk("t1_addr1", 32'(rom_addr), 'h11);
        tick(); tick();
        chk("t1_i_vld", 32'(tx_valid), 1);
        chk("t1_i", 32'(tx_data), "I");
        tick();
        chk("t1_len2", 32'(len), 2);
        tick();
        tail("t1", 2);
        chk("t1_ovf", 32'(ovf), 0);

        // Same message with backpressure on the first byte and a START while busy
        base = 19'h10; start = 1'b1; ready = 1'b0;
        tick(); start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 7; i++) begin
            chk("t2_hold_vld", 32'(tx_valid), 1);
            chk("t2_hold_h", 32'(tx_data), "H");
            if (i == 3) begin
                start = 1'b1;
                base = 19'h20;
            end
            tick();
            start = 1'b0;
        end
        chk("t2_hold_end", 32'(tx_data), "H");
        chk("t2_addr_kept", 32'(rom_addr), 'h10);
        chk("t2_len0", 32'(len), 0);
        ready = 1'b1;
        tick();
        chk("t2_len1", 32'(len), 1);
        tick(); tick();
        chk("t2_i_vld", 32'(tx_valid), 1);
        chk("t2_i", 32'(tx_data), "I");
        tick();
        chk("t2_len2", 32'(len), 2);
        tick();
        tail("t2", 2);

        // Empty message
        base = 19'h20; start = 1'b1;
        tick(); start = 1'b0;
        chk("t3_busy", 32'(busy), 1);
        tick();
        chk("t3_novld", 32'(tx_valid), 0);
        tail("t3", 0);

        // MaxLen=4 cutoff on a 10-byte string
        base = 19'h30; start2 = 1'b1;
        tick(); start2 = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_vld", 32'(tx_valid2), 1);
            chk("t4_byte", 32'(tx_data2), 32'(8'h30 + i));
            tick();
            chk("t4_len", 32'(len2), 32'(i + 1));
            tick();
        end
`ifdef MSG_STREAMER_CRLF_EN
        tick();
        chk("t4_cr", 32'(tx_data2), 'h0D);
        tick();
        chk("t4_lf", 32'(tx_data2), 'h0A);
`endif
        tick();
        chk("t4_done", 32'(done2), 1);
        chk("t4_ovf", 32'(ovf2), 1);
        chk("t4_len4", 32'(len2), 4);
        tick();
        chk("t4_done_drop", 32'(done2), 0);
        chk("t4_ovf_sticky", 32'(ovf2), 1);
        chk("t4_idle", 32'(busy2), 0);
        base = 19'h20; start2 = 1'b1;
        tick(); start2 = 1'b0;
        chk("t4_ovf_clr", 32'(ovf2), 0);
        chk("t4_len_clr", 32'(len2), 0);
        tick();
`ifdef MSG_STREAMER_CRLF_EN
        tick(); tick();
`endif
        tick();
        chk("t4_done2", 32'(done2), 1);
        tick();

        // Asynchronous reset while a byte is pending, then a fresh message
        base = 19'h10; start = 1'b1;
        tick(); start = 1'b0; ready = 1'b0;
        tick(); tick();
        chk("t5_pre_vld", 32'(tx_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_vld", 32'(tx_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_addr", 32'(rom_addr), 0);
        chk("t5_rst_data", 32'(tx_data), 0);
        #2 rst = 1'b0;
        tick();
        ready = 1'b1; base = 19'h40; start = 1'b1;
        tick(); start = 1'b0;
        chk("t5_addr", 32'(rom_addr), 'h40);
        tick(); tick();
        chk("t5_o_vld", 32'(tx_valid), 1);
        chk("t5_o", 32'(tx_data), "O");
        tick(); tick(); tick();
        chk("t5_k", 32'(tx_data), "K");
        tick();
        chk("t5_len2", 32'(len), 2);
        tick();
        tail("t5", 2);

        // Single-character message
        base = 19'h50; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("t6_a_vld", 32'(tx_valid), 1);
        chk("t6_a", 32'(tx_data), "A");
        tick(); tick();
        tail("t6", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
